// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the LCD text feeder.
// The helper functions build DDRAM commands and classify received bytes.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] LCD_LINE1_OFS     = 8'h40;
    localparam logic [7:0] ASCII_CR          = 8'h0D;
    localparam logic [7:0] ASCII_LF          = 8'h0A;
    localparam logic [7:0] ASCII_BS          = 8'h08;
    localparam logic [7:0] ASCII_SPACE       = 8'h20;
    localparam logic [7:0] PRINT_MIN         = 8'h20;
    localparam logic [7:0] PRINT_MAX         = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_PRESENT
    } feed_state_t;

    function automatic logic [7:0] ddram_addr(
        input logic       line,
        input logic [3:0] col
    );
        logic [7:0] ofs;
        ofs = line ? LCD_LINE1_OFS : 8'h00;
        return LCD_CMD_SET_DDRAM | ofs | {4'h0, col};
    endfunction

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_MIN) && (b <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with wrap-bit pointers; flush wins over push and pop.
// Storage is not reset, only the pointers are.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   CLK_400Hz,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge CLK_400Hz) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge CLK_400Hz or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_text_feeder.sv
// Buffers UART bytes, tracks a 2-line cursor and hands printable
// characters with their DDRAM address to the LCD FSM.
module lcd_text_feeder
    import lcd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int COLS  = 16
) (
    input  logic                   CLK_400Hz,
    input  logic                   resetn,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   cursor_clear,
    output logic [7:0]             characterIN,
    output logic [7:0]             addressIN,
    output logic                   char_valid,
    input  logic                   char_ack,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    feed_state_t state;
    logic [7:0]  byte_q;
    logic [7:0]  head;
    logic        full;
    logic        empty;
    logic        pop;
    logic        line;
    logic [3:0]  col;

    assign rx_ready = ~full;
    assign pop      = (state == ST_FETCH);

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK_400Hz(CLK_400Hz),
        .resetn   (resetn),
        .flush    (cursor_clear),
        .push     (rx_valid),
        .pop      (pop),
        .wdata    (rx_data),
        .rdata    (head),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

    always_ff @(posedge CLK_400Hz or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            byte_q      <= 8'h00;
            line        <= 1'b0;
            col         <= '0;
            char_valid  <= 1'b0;
            characterIN <= ASCII_SPACE;
            addressIN   <= LCD_CMD_SET_DDRAM;
        end else if (cursor_clear) begin
            state      <= ST_IDLE;
            line       <= 1'b0;
            col        <= '0;
            char_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    byte_q <= head;
                    state  <= ST_DECODE;
                end
                ST_DECODE: begin
                    state <= ST_IDLE;
                    if (byte_q == ASCII_CR) begin
                        col <= '0;
                    end else if (byte_q == ASCII_LF) begin
                        line <= ~line;
                        col  <= '0;
                    end else if (byte_q == ASCII_BS) begin
                        // backspace stops at column 0, never crosses lines
                        if (col != '0) begin
                            col <= col - 4'd1;
                        end
                    end else if (is_printable(byte_q)) begin
                        characterIN <= byte_q;
                        addressIN   <= ddram_addr(line, col);
                        char_valid  <= 1'b1;
                        state       <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (char_ack) begin
                        char_valid <= 1'b0;
                        state      <= ST_IDLE;
                        if (col == LAST_COL) begin
                            col  <= '0;
                            line <= ~line;
                        end else begin
                            col <= col + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Self-checking bench: directed scenarios plus random byte streams
// compared against a cursor model of the text feeder.
module tb_lcd_text_feeder;

    logic       CLK_400Hz = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       cursor_clear = 1'b0;
    logic [7:0] characterIN;
    logic [7:0] addressIN;
    logic       char_valid;
    logic       char_ack = 1'b0;
    logic [3:0] fifo_level;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  log_addr[$];
    logic        m_line = 1'b0;
    int          m_col = 0;
    int          pres_cnt = 0;
    int          last_pres_cyc = 0;
    int          last_acc_cyc = 0;
    int          ack_dly = -1;
    bit          ack_hold = 1'b0;

    lcd_text_feeder #(
        .DEPTH(8),
        .COLS (16)
    ) dut (
        .CLK_400Hz   (CLK_400Hz),
        .resetn      (resetn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cursor_clear(cursor_clear),
        .characterIN (characterIN),
        .addressIN   (addressIN),
        .char_valid  (char_valid),
        .char_ack    (char_ack),
        .fifo_level  (fifo_level)
    );

    always #5 CLK_400Hz = ~CLK_400Hz;

    always @(posedge CLK_400Hz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference: cursor on a 2x16 grid, one queue entry per visible char
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] a;
        if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_line = ~m_line;
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col = m_col - 1;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            a = 8'h80 + (m_line ? 8'h40 : 8'h00) + 8'(m_col);
            exp_q.push_back({b, a});
            m_col = m_col + 1;
            if (m_col == 16) begin
                m_col = 0;
                m_line = ~m_line;
            end
        end
    endtask

    initial begin : monitor
        bit seen;
        int d;
        logic [15:0] e;
        seen = 1'b0;
        forever begin
            @(negedge CLK_400Hz);
            if (!char_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                last_pres_cyc = cyc;
                pres_cnt++;
                log_addr.push_back(addressIN);
                if (exp_q.size() == 0) begin
                    check("spurious_char", {16'h0, characterIN, addressIN}, 32'h0);
                    e = {characterIN, addressIN};
                end else begin
                    e = exp_q.pop_front();
                    check("char", characterIN, e[15:8]);
                    check("addr", addressIN, e[7:0]);
                end
                d = (ack_dly >= 0) ? ack_dly : int'($urandom_range(0, 3));
                repeat (d) @(negedge CLK_400Hz);
                while (ack_hold && char_valid) @(negedge CLK_400Hz);
                if (char_valid) begin
                    check("hold_stable", {characterIN, addressIN}, e);
                    char_ack = 1'b1;
                    @(negedge CLK_400Hz);
                    char_ack = 1'b0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge CLK_400Hz);
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 500) begin
            @(negedge CLK_400Hz);
            n++;
        end
        if (!rx_ready) begin
            check("rx_accept_timeout", n, 0);
            rx_valid = 1'b0;
            return;
        end
        @(posedge CLK_400Hz);
        #1;
        last_acc_cyc = cyc;
        model_byte(b);
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || char_valid || fifo_level != 0) && n < 3000) begin
            @(negedge CLK_400Hz);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (4) @(negedge CLK_400Hz);
    endtask

    task automatic do_clear();
        @(negedge CLK_400Hz);
        cursor_clear = 1'b1;
        @(negedge CLK_400Hz);
        cursor_clear = 1'b0;
        exp_q.delete();
        m_line = 1'b0;
        m_col = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!char_valid && n < 200) begin
            @(negedge CLK_400Hz);
            n++;
        end
        check(tag, char_valid, 1);
    endtask

    initial begin
        int base;
        int acc;
        int r;
        logic [7:0] b;
        logic [7:0] seq3[8];
        seq3 = '{8'h61, 8'h0A, 8'h62, 8'h0D, 8'h63, 8'h08, 8'h08, 8'h64};

        repeat (2) @(negedge CLK_400Hz);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_valid", char_valid, 0);
        check("rst_char", characterIN, 8'h20);
        check("rst_addr", addressIN, 8'h80);
        resetn = 1'b1;

        // "AB" with fixed ack delay and latency check
        ack_dly = 2;
        base = log_addr.size();
        send_byte(8'h41);
        acc = last_acc_cyc;
        wait_valid("AB_valid_A");
        @(negedge CLK_400Hz);
        check("latency", last_pres_cyc - acc, 3);
        send_byte(8'h42);
        wait_drain();
        check("AB_addr0", log_addr[base], 8'h80);
        check("AB_addr1", log_addr[base + 1], 8'h81);
        ack_dly = -1;

        // line wrap
        do_clear();
        base = log_addr.size();
        repeat (16) send_byte(8'h78);
        send_byte(8'h79);
        wait_drain();
        check("wrap_first", log_addr[base], 8'h80);
        check("wrap_16th", log_addr[base + 15], 8'h8F);
        check("wrap_y", log_addr[base + 16], 8'hC0);

        // control characters
        do_clear();
        base = log_addr.size();
        foreach (seq3[i]) send_byte(seq3[i]);
        wait_drain();
        check("ctl_count", log_addr.size() - base, 4);
        check("ctl_a", log_addr[base], 8'h80);
        check("ctl_b", log_addr[base + 1], 8'hC0);
        check("ctl_c", log_addr[base + 2], 8'hC0);
        check("ctl_d", log_addr[base + 3], 8'hC0);

        // back-pressure with ack withheld
        do_clear();
        ack_hold = 1'b1;
        base = pres_cnt;
        for (int i = 0; i < 9; i++) send_byte(8'h41 + 8'(i));
        repeat (3) @(negedge CLK_400Hz);
        check("full_level", fifo_level, 8);
        check("full_rx_ready", rx_ready, 0);
        check("full_valid", char_valid, 1);
        fork
            send_byte(8'h4A);
        join_none
        repeat (5) @(negedge CLK_400Hz);
        check("full_level_hold", fifo_level, 8);
        check("full_one_pres", pres_cnt - base, 1);
        ack_hold = 1'b0;
        wait fork;
        wait_drain();
        check("full_no_loss", pres_cnt - base, 10);

        // cursor_clear while presenting
        do_clear();
        ack_hold = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
        r = 0;
        while (!(char_valid && fifo_level == 3) && r < 200) begin
            @(negedge CLK_400Hz);
            r++;
        end
        check("clr_pre_level", fifo_level, 3);
        do_clear();
        check("clr_valid", char_valid, 0);
        check("clr_level", fifo_level, 0);
        check("clr_rx_ready", rx_ready, 1);
        ack_hold = 1'b0;
        base = log_addr.size();
        send_byte(8'h7A);
        wait_drain();
        check("clr_z_addr", log_addr[base], 8'h80);

        // unprintable bytes are dropped
        base = log_addr.size();
        send_byte(8'h07);
        send_byte(8'hFF);
        repeat (10) @(negedge CLK_400Hz);
        check("junk_none", log_addr.size() - base, 0);
        check("junk_valid", char_valid, 0);
        send_byte(8'h71);
        wait_drain();
        check("junk_q_addr", log_addr[base], 8'h81);

        // random stream
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 75) b = 8'($urandom_range(32, 126));
            else if (r < 80) b = 8'h0D;
            else if (r < 85) b = 8'h0A;
            else if (r < 92) b = 8'h08;
            else if (r < 96) b = 8'($urandom_range(0, 31));
            else b = 8'($urandom_range(127, 255));
            send_byte(b);
            repeat ($urandom_range(0, 2)) @(negedge CLK_400Hz);
        end
        wait_drain();

        // asynchronous reset during a handshake
        ack_hold = 1'b1;
        send_byte(8'h52);
        send_byte(8'h53);
        wait_valid("arst_valid");
        #2;
        resetn = 1'b0;
        #1;
        check("arst_valid_low", char_valid, 0);
        check("arst_char", characterIN, 8'h20);
        check("arst_addr", addressIN, 8'h80);
        check("arst_level", fifo_level, 0);
        check("arst_rx_ready", rx_ready, 1);
        exp_q.delete();
        ack_hold = 1'b0;
        repeat (2) @(negedge CLK_400Hz);
        resetn = 1'b1;
        repeat (2) @(negedge CLK_400Hz);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
